div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Iterative radix-2 restoring divider for the execute stage, serving MIPS DIV/DIVU. It is the counterpart to the pipelined Booth/Wallace multiplier.
- Accepts a 32-bit dividend and divisor, either signed or unsigned.
- Produces a quotient (LO) and remainder (HI) after a fixed latency.
- Uses a start/busy/done handshake toward the pipeline controller and supports a cancel input for exception flush.

Parameters:
- DATA_W, 32, operand/result width; the iteration count equals DATA_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request new division; accepted only when busy=0
- divop  in  1  0: unsigned, 1: signed (two's complement)
- src0  in  DATA_W  dividend
- src1  in  DATA_W  divisor
- cancel  in  1  abort current operation (pipeline flush)
- busy  out  1  operation in progress (state != IDLE)
- done  out  1  one-cycle pulse; quot/rem valid
- quot  out  DATA_W  quotient (to LO)
- rem  out  DATA_W  remainder (to HI)

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-low on rst_n; the clock is clk.
  - On reset: state=IDLE, busy=0, done=0, quot=0, rem=0, internal counter/registers=0.
  - Reset mid-operation aborts with no done pulse.
- FSM states: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - If start=1 and cancel=0 at a rising edge, latch src0, src1 and divop.
  - Compute operand magnitudes: when divop=1, take the absolute value of any negative operand.
  - Record the quotient sign as src0[31]^src1[31] and the remainder sign as src0[31] (both forced to 0 when divop=0).
  - Clear the partial remainder (DATA_W+1 bits), load the dividend magnitude into the quotient shift register, set count=0, and go to CALC.
- CALC, one iteration per cycle:
  - Shift {partial remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - count increments; after iteration DATA_W-1 (count==DATA_W-1), go to DONE.
- DONE:
  - quot/rem are registered on entry to this state with sign correction applied: negate the quotient if the quotient sign is set, negate the remainder if the remainder sign is set.
  - done=1 for exactly this cycle, then IDLE.
  - quot/rem hold their values until the next DONE (or reset).
- Latency:
  - If start is accepted at edge C0, busy=1 in cycles C1..C33 and done=1 in C33.
  - busy=0 from C34, when a new start may be accepted.
- start while busy=1 (CALC or DONE) is ignored; the operands are not re-latched.
- cancel:
  - In CALC or DONE, cancel=1 forces IDLE at the next edge.
  - done is not asserted on or after that edge; quot/rem keep their previous values.
  - In IDLE, cancel=1 takes priority over start (the request is dropped).
  - If cancel is asserted in the DONE cycle, done is still 1 in that cycle (already committed); the state returns to IDLE as normal.
- Divide by zero (src1==0), in either mode:
  - Still takes the full latency.
  - Result is quot=all ones, rem=src0 unmodified (deterministic value for the software-undefined case).
- Signed overflow (0x80000000 / 0xFFFFFFFF, divop=1): quot=0x80000000 and rem=0 via natural two's-complement wrap; no trap.
- Magnitude of 0x80000000 is represented correctly in the DATA_W-bit unsigned path (no overflow in the abs step).
- Remainder sign follows the dividend and |rem| < |divisor| (truncating division), matching MIPS semantics.

Test Plan:
- Unsigned 100 / 7, start at C0 -> busy C1..C33, done only in C33, quot=14, rem=2.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 7 / -2 -> quot=0xFFFFFFFD, rem=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0. Unsigned 0xFFFFFFFF / 0x10 -> quot=0x0FFFFFFF, rem=0xF.
- Divide by zero, unsigned and signed with src0=0x00001234 -> quot=0xFFFFFFFF, rem=0x00001234, done in C33.
- Sequence:
  - Start 50/5, then pulse start with different operands at C5 -> ignored; result is quot=10, rem=0.
  - Cancel at C10 -> busy=0 at C11, no done, quot/rem unchanged.
  - Immediate new start 9/4 -> quot=2, rem=1 after 33 cycles.
- rst_n=0 at C20 of an operation -> next cycle busy=0, done=0, quot=0, rem=0; no done pulse afterwards until a new start.

Source files
------------

// File: rtl/div_iter_if.sv
// Handshake and operand/result bundle between the pipeline controller and the
// iterative divider.
interface div_iter_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              divop;
  logic [DATA_W-1:0] src0;
  logic [DATA_W-1:0] src1;
  logic              cancel;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;

  modport master (
    output start, divop, src0, src1, cancel,
    input  busy, done, quot, rem
  );

  modport slave (
    input  start, divop, src0, src1, cancel,
    output busy, done, quot, rem
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on operand
// magnitudes, sign fix-up applied when results are registered on entry to DONE.
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_iter_if.slave  dif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pr_q, pr_d;      // partial remainder
  logic [DATA_W-1:0] qr_q, qr_d;      // dividend in, quotient bits out
  logic [DATA_W-1:0] dvsr_q, dvsr_d;  // divisor magnitude
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] it_pr;
  logic [DATA_W-1:0] it_qr;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  // One iteration: shift {pr,qr} left, trial-subtract, borrow means restore.
  always_comb begin
    shifted = {pr_q, qr_q[DATA_W-1]};
    trial   = shifted - {1'b0, dvsr_q};
    it_pr   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    it_qr   = {qr_q[DATA_W-2:0], ~trial[DATA_W]};
  end

  // Two's-complement negate of the most negative value wraps to itself, which
  // is exactly its unsigned magnitude.
  always_comb begin
    a_mag = (dif.divop && dif.src0[DATA_W-1]) ? -dif.src0 : dif.src0;
    b_mag = (dif.divop && dif.src1[DATA_W-1]) ? -dif.src1 : dif.src1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    qr_d    = qr_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (dif.start && !dif.cancel) begin
          pr_d    = '0;
          qr_d    = a_mag;
          dvsr_d  = b_mag;
          qneg_d  = dif.divop & (dif.src0[DATA_W-1] ^ dif.src1[DATA_W-1]);
          rneg_d  = dif.divop & dif.src0[DATA_W-1];
          dz_d    = (dif.src1 == '0);
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (dif.cancel) begin
          state_d = S_IDLE;
        end else begin
          pr_d  = it_pr;
          qr_d  = it_qr;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Divide by zero leaves |src0| in the remainder, so the normal
            // sign fix-up returns src0 itself; only the quotient is forced.
            quot_d  = dz_q ? '1 : (qneg_q ? -it_qr : it_qr);
            rem_d   = rneg_q ? -it_pr : it_pr;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      qr_q    <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      qr_q    <= qr_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign dif.busy = (state_q != S_IDLE);
  assign dif.done = (state_q == S_DONE);
  assign dif.quot = quot_q;
  assign dif.rem  = rem_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: stimulus pushes expected {quot,rem} into a
// scoreboard queue, a monitor pops and compares on every done pulse.
module tb_div_iter;

  logic clk;
  logic rst_n;

  div_iter_if #(.DATA_W(32)) dif ();

  div_iter #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
    dif.start = 1'b1;
    dif.divop = sg;
    dif.src0  = a;
    dif.src1  = b;
    step();
    dif.start = 1'b0;
  endtask

  // Full operation with cycle-exact busy/done checks; inj>0 pulses a stray
  // start with other operands at that cycle, which must be ignored.
  task automatic run(input logic sg, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input int inj);
    exp_q.push_back({eq, er});
    issue(sg, a, b);
    for (int k = 1; k <= 33; k++) begin
      chk($sformatf("busy_c%0d", k), {31'd0, dif.busy}, 32'd1);
      chk($sformatf("done_c%0d", k), {31'd0, dif.done}, (k == 33) ? 32'd1 : 32'd0);
      if (k == inj) begin
        dif.start = 1'b1;
        dif.divop = ~sg;
        dif.src0  = ~a;
        dif.src1  = 32'd3;
      end else begin
        dif.start = 1'b0;
      end
      step();
    end
    dif.start = 1'b0;
    chk("busy_c34", {31'd0, dif.busy}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    dif.start  = 1'b0;
    dif.divop  = 1'b0;
    dif.src0   = '0;
    dif.src1   = '0;
    dif.cancel = 1'b0;

    fork
      begin : stim
        step(); step(); step();
        chk("rst_busy", {31'd0, dif.busy}, 32'd0);
        chk("rst_done", {31'd0, dif.done}, 32'd0);
        chk("rst_quot", dif.quot, 32'd0);
        chk("rst_rem",  dif.rem,  32'd0);
        rst_n = 1'b1;
        step();

        run(1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        0);
        run(1'b1, 32'hFFFFFFF9,   32'h00000002, 32'hFFFFFFFD,  32'hFFFFFFFF, 0);
        run(1'b1, 32'h00000007,   32'hFFFFFFFE, 32'hFFFFFFFD,  32'h00000001, 0);
        run(1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'h00000000, 0);
        run(1'b0, 32'hFFFFFFFF,   32'h00000010, 32'h0FFFFFFF,  32'h0000000F, 0);
        run(1'b0, 32'h00001234,   32'h00000000, 32'hFFFFFFFF,  32'h00001234, 0);
        run(1'b1, 32'h00001234,   32'h00000000, 32'hFFFFFFFF,  32'h00001234, 0);
        run(1'b1, 32'hFFFFFFF9,   32'h00000000, 32'hFFFFFFFF,  32'hFFFFFFF9, 0);
        run(1'b0, 32'd50,         32'd5,        32'd10,        32'd0,        5);

        // cancel beats start while idle
        dif.cancel = 1'b1;
        issue(1'b0, 32'd77, 32'd7);
        dif.cancel = 1'b0;
        chk("idle_cancel_busy", {31'd0, dif.busy}, 32'd0);

        // cancel mid-calculation: no done, results untouched
        issue(1'b0, 32'd1000, 32'd3);
        for (int k = 1; k < 10; k++) step();
        chk("pre_cancel_busy", {31'd0, dif.busy}, 32'd1);
        dif.cancel = 1'b1;
        step();
        dif.cancel = 1'b0;
        chk("cancel_busy", {31'd0, dif.busy}, 32'd0);
        chk("cancel_done", {31'd0, dif.done}, 32'd0);
        chk("cancel_quot", dif.quot, 32'd10);
        chk("cancel_rem",  dif.rem,  32'd0);
        run(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 0);

        // reset mid-operation
        issue(1'b0, 32'd100, 32'd7);
        for (int k = 1; k < 20; k++) step();
        rst_n = 1'b0;
        step();
        chk("midrst_busy", {31'd0, dif.busy}, 32'd0);
        chk("midrst_done", {31'd0, dif.done}, 32'd0);
        chk("midrst_quot", dif.quot, 32'd0);
        chk("midrst_rem",  dif.rem,  32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) step();
        chk("post_rst_busy", {31'd0, dif.busy}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);
      end
      begin : mon
        forever begin
          @(negedge clk);
          if (dif.done === 1'b1) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_done got=quot %h rem %h want=no done", dif.quot, dif.rem);
            end else begin
              logic [63:0] e;
              e = exp_q.pop_front();
              chk("sb_quot", dif.quot, e[63:32]);
              chk("sb_rem",  dif.rem,  e[31:0]);
            end
          end
        end
      end
    join_any
    disable fork;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
